// File: rtl/twiddle_gen.sv
// Streaming FFT twiddle generator: W_N^k from a quarter-wave cosine ROM with quadrant decode.
// Define TWD_GEN_CONJ_EN to honour the inv input (conjugated twiddles for the inverse FFT).
module twiddle_gen #(
    parameter int unsigned TW_W   = 9,
    parameter int unsigned N_LOG2 = 6,
    parameter int unsigned C      = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              inv,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [N_LOG2-1:0] out_idx,
    output logic [TW_W-1:0]   tw_re,
    output logic [TW_W-1:0]   tw_im
);
    localparam int unsigned RB   = N_LOG2 - C;
    localparam int unsigned QW   = N_LOG2 - 1;
    localparam int unsigned NQ   = 1 << (N_LOG2 - 2);
    localparam int unsigned FRAC = 48;
    localparam logic [127:0] PI_FX = 128'd884279719003555;
    localparam logic [N_LOG2-1:0] IDX_MAX = '1;

    // round(2^(TW_W-2) * cos(2*pi*j/N)) via a fixed-point Taylor series, half away from zero
    function automatic logic [TW_W-1:0] qval(input int unsigned j);
        logic [127:0]        x;
        logic [127:0]        x2;
        logic [127:0]        term;
        logic signed [127:0] acc;
        x    = (PI_FX * 128'(j)) >> (N_LOG2 - 1);
        x2   = (x * x) >> FRAC;
        term = 128'(1) << FRAC;
        acc  = $signed(term);
        for (int n = 1; n <= 16; n++) begin
            term = ((term * x2) >> FRAC) / 128'((2 * n - 1) * (2 * n));
            if (n % 2 == 1) acc = acc - $signed(term);
            else            acc = acc + $signed(term);
        end
        acc = (acc + $signed(128'(1) << (FRAC - TW_W + 1))) >>> (FRAC - TW_W + 2);
        return acc[TW_W-1:0];
    endfunction

    logic [TW_W-1:0] qtab [NQ+1];
    for (genvar j = 0; j <= NQ; j++) begin : g_qtab
        localparam logic [TW_W-1:0] QJ = qval(j);
        assign qtab[j] = QJ;
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              state_q, state_d;
    logic [N_LOG2-1:0]   idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                s1_valid_q, s1_valid_d;
    logic [N_LOG2-1:0]   s1_idx_q, s1_idx_d;
    logic                s1_last_q, s1_last_d;
    logic [1:0]          s1_quad_q, s1_quad_d;
    logic [N_LOG2-3:0]   s1_rem_q, s1_rem_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [N_LOG2-1:0]   out_idx_q, out_idx_d;
    logic [TW_W-1:0]     tw_re_q, tw_re_d;
    logic [TW_W-1:0]     tw_im_q, tw_im_d;

    logic                pipe_en, issue, last_hs;
    logic [RB-1:0]       row, row_rev;
    logic [C-1:0]        col;
    logic [N_LOG2-1:0]   k;
    logic [QW-1:0]       ia, ib;
    logic [TW_W-1:0]     mag_a, mag_b, re_mag, im_mag;
    logic                re_neg, im_neg;

`ifdef TWD_GEN_CONJ_EN
    logic inv_q, inv_d;
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    always_comb begin
        // Whole pipe freezes only while a presented sample is refused
        pipe_en = !(out_valid_q && !out_ready);
        issue   = pipe_en && ((state_q == StIdle && start) || state_q == StRun);
        last_hs = out_valid_q && out_ready && out_last_q;

        row     = idx_q[N_LOG2-1:C];
        col     = idx_q[C-1:0];
        row_rev = '0;
        for (int b = 0; b < RB; b++) row_rev[b] = row[RB-1-b];
        k = {{C{1'b0}}, row_rev} * {{RB{1'b0}}, col};

        state_d = state_q;
        idx_d   = idx_q;
        if (issue) begin
            idx_d   = idx_q + 1'b1;
            state_d = (idx_q == IDX_MAX) ? StDrain : StRun;
        end
        if (state_q == StDrain && last_hs) state_d = StIdle;
        busy_d = (state_d != StIdle);
        done_d = (state_q == StDrain) && last_hs;
`ifdef TWD_GEN_CONJ_EN
        inv_d = inv_q;
        if (issue && state_q == StIdle) inv_d = inv;
`endif

        s1_valid_d = s1_valid_q;
        s1_idx_d   = s1_idx_q;
        s1_last_d  = s1_last_q;
        s1_quad_d  = s1_quad_q;
        s1_rem_d   = s1_rem_q;
        if (pipe_en) begin
            s1_valid_d = issue;
            if (issue) begin
                s1_idx_d  = idx_q;
                s1_last_d = (idx_q == IDX_MAX);
                s1_quad_d = k[N_LOG2-1 -: 2];
                s1_rem_d  = k[N_LOG2-3:0];
            end
        end

        ia     = {1'b0, s1_rem_q};
        ib     = QW'(NQ) - ia;
        mag_a  = qtab[ia];
        mag_b  = qtab[ib];
        re_mag = s1_quad_q[0] ? mag_b : mag_a;
        im_mag = s1_quad_q[0] ? mag_a : mag_b;
        re_neg = ^s1_quad_q;
`ifdef TWD_GEN_CONJ_EN
        im_neg = ~s1_quad_q[1] ^ inv_q;
`else
        im_neg = ~s1_quad_q[1];
`endif

        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        tw_re_d     = tw_re_q;
        tw_im_d     = tw_im_q;
        if (pipe_en) begin
            out_valid_d = s1_valid_q;
            out_last_d  = s1_valid_q && s1_last_q;
            if (s1_valid_q) begin
                out_idx_d = s1_idx_q;
                tw_re_d   = re_neg ? -re_mag : re_mag;
                tw_im_d   = im_neg ? -im_mag : im_mag;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_last_q   <= 1'b0;
            s1_quad_q   <= '0;
            s1_rem_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            tw_re_q     <= '0;
            tw_im_q     <= '0;
`ifdef TWD_GEN_CONJ_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            s1_last_q   <= s1_last_d;
            s1_quad_q   <= s1_quad_d;
            s1_rem_q    <= s1_rem_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            tw_re_q     <= tw_re_d;
            tw_im_q     <= tw_im_d;
`ifdef TWD_GEN_CONJ_EN
            inv_q       <= inv_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign tw_re     = tw_re_q;
    assign tw_im     = tw_im_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Bench for twiddle_gen: real-math model feeding a scoreboard, spot-vector table, timing and
// corner-case sequences; a second wide instance (N=512, 16-bit) is swept against the same model.
`timescale 1ns/1ps
module tb_twiddle_gen;
    localparam int TW_W = 9, N_LOG2 = 6, C = 3, N = 64;
    localparam int TW2 = 16, NL2 = 9, C2 = 3, N2 = 512;
`ifdef TWD_GEN_CONJ_EN
    localparam bit CONJ = 1'b1;
`else
    localparam bit CONJ = 1'b0;
`endif
    localparam real PI = 3.14159265358979323846;

    typedef struct { int idx; int re; int im; bit last; } exp_t;
    typedef struct { int idx; int re; int im; } vec_t;

    logic clk = 1'b0, rstn = 1'b0, rstn2 = 1'b0;
    logic start = 1'b0, inv = 1'b0, out_ready = 1'b1, start2 = 1'b0;
    logic busy, done, out_valid, out_last;
    logic [N_LOG2-1:0] out_idx;
    logic [TW_W-1:0] tw_re, tw_im;
    logic busy2, done2, v2, last2;
    logic [NL2-1:0] idx2;
    logic [TW2-1:0] re2, im2;

    int nvec = 0, nerr = 0, cyc = 0;
    int start_cyc, first_cyc, last_cyc, n_stall, n2;
    exp_t sb[$];
    int got_re [N];
    int got_im [N];
    logic prev_valid, prev_stall;
    logic [N_LOG2-1:0] h_idx;
    logic [TW_W-1:0] h_re, h_im;

    twiddle_gen #(.TW_W(TW_W), .N_LOG2(N_LOG2), .C(C)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .inv(inv), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .out_idx(out_idx),
        .tw_re(tw_re), .tw_im(tw_im)
    );

    twiddle_gen #(.TW_W(TW2), .N_LOG2(NL2), .C(C2)) u_wide (
        .clk(clk), .rstn(rstn2), .start(start2), .inv(1'b0), .busy(busy2), .done(done2),
        .out_valid(v2), .out_ready(1'b1), .out_last(last2), .out_idx(idx2),
        .tw_re(re2), .tw_im(im2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic void model(input int i, input int tw, input int nl, input int c,
                                  input bit cj, output int re, output int im);
        int row, col, rev, k;
        real ang, s;
        row = i >> c;
        col = i & ((1 << c) - 1);
        rev = 0;
        for (int b = 0; b < nl - c; b++) if (row[b]) rev = rev | (1 << (nl - c - 1 - b));
        k = (rev * col) % (1 << nl);
        ang = 2.0 * PI * real'(k) / real'(1 << nl);
        s = real'(1 << (tw - 2));
        re = rnd(s * $cos(ang));
        im = rnd(-s * $sin(ang));
        if (cj) im = -im;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit iv);
        exp_t e;
        int re, im;
        start = 1'b1;
        inv = iv;
        start_cyc = cyc;
        for (int i = 0; i < N; i++) begin
            model(i, TW_W, N_LOG2, C, iv & CONJ, re, im);
            e = '{i, re, im, i == N - 1};
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
        inv = 1'b0;
        chk("busy_after_start", int'(busy), 1);
    endtask

    task automatic run_until_done(input bit rnd_ready, input int poke_at, output int dcyc);
        dcyc = -1;
        for (int t = 0; t < 4 * N + 50; t++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            start = (poke_at > 0 && t == poke_at);
            tick();
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (dcyc < 0) chk("done_timeout", 0, 1);
    endtask

    // Scoreboard pop, stall stability and timing capture for the main instance
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            prev_valid <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_idx", int'(out_idx), int'(h_idx));
                chk("hold_re", int'($signed(tw_re)), int'($signed(h_re)));
                chk("hold_im", int'($signed(tw_im)), int'($signed(h_im)));
            end
            if (out_valid && !prev_valid) begin
                first_cyc <= cyc;
                chk("first_idx", int'(out_idx), 0);
            end
            if (out_valid && !out_ready) n_stall <= n_stall + 1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", int'(out_idx), -1);
                else begin
                    e = sb.pop_front();
                    chk("sb_idx", int'(out_idx), e.idx);
                    chk("sb_re", int'($signed(tw_re)), e.re);
                    chk("sb_im", int'($signed(tw_im)), e.im);
                    chk("sb_last", int'(out_last), int'(e.last));
                end
                got_re[out_idx] <= int'($signed(tw_re));
                got_im[out_idx] <= int'($signed(tw_im));
                if (out_last) last_cyc <= cyc;
            end
            prev_valid <= out_valid;
            prev_stall <= out_valid && !out_ready;
            h_idx <= out_idx;
            h_re  <= tw_re;
            h_im  <= tw_im;
        end
    end

    always @(negedge clk) begin
        int mre, mim;
        if (rstn2 && v2) begin
            model(n2, TW2, NL2, C2, 1'b0, mre, mim);
            chk("wide_idx", int'(idx2), n2);
            chk("wide_re", int'($signed(re2)), mre);
            chk("wide_im", int'($signed(im2)), mim);
            chk("wide_last", int'(last2), int'(n2 == N2 - 1));
            n2 <= n2 + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        int dcyc, s0, found;
        vt[0] = '{0, 128, 0};
        vt[1] = '{9, 118, -49};
        vt[2] = '{12, 0, -128};
        vt[3] = '{33, 127, -13};
        vt[4] = '{63, 13, 127};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_idx", int'(out_idx), 0);
        chk("rst_re", int'(tw_re), 0);
        chk("rst_im", int'(tw_im), 0);
        rstn = 1'b1;
        rstn2 = 1'b1;
        tick();
        tick();
        chk("idle_valid", int'(out_valid), 0);

        // Forward sweep, ready held high
        start2 = 1'b1;
        do_start(1'b0);
        start2 = 1'b0;
        run_until_done(1'b0, 0, dcyc);
        chk("first_lat", first_cyc - start_cyc, 2);
        chk("last_lat", last_cyc - start_cyc, N + 1);
        chk("done_lat", dcyc - start_cyc, N + 2);
        chk("sb_empty_fwd", sb.size(), 0);
        for (int i = 0; i < 5; i++) begin
            chk("vec_re", got_re[vt[i].idx], vt[i].re);
            chk("vec_im", got_im[vt[i].idx], vt[i].im);
        end
        tick();
        chk("done_one_cycle", int'(done), 0);
        chk("busy_end", int'(busy), 0);

        // Random backpressure, inv=1, extra start while busy must be ignored
        tick();
        s0 = n_stall;
        do_start(1'b1);
        run_until_done(1'b1, 10, dcyc);
        chk("stall_done_lat", dcyc - start_cyc, N + 2 + (n_stall - s0));
        chk("stall_last_lat", last_cyc - start_cyc, N + 1 + (n_stall - s0));
        chk("sb_empty_rnd", sb.size(), 0);
        chk("inv_re9", got_re[9], 118);
        chk("inv_im9", got_im[9], CONJ ? 49 : -49);
        chk("inv_re63", got_re[63], 13);
        chk("inv_im63", got_im[63], CONJ ? -127 : 127);

        // Start on the done cycle
        chk("done_at_restart", int'(done), 1);
        do_start(1'b0);
        run_until_done(1'b0, 0, dcyc);
        chk("b2b_first_lat", first_cyc - start_cyc, 2);
        chk("b2b_done_lat", dcyc - start_cyc, N + 2);
        chk("sb_empty_b2b", sb.size(), 0);

        // Asynchronous reset mid-sequence
        tick();
        tick();
        do_start(1'b0);
        found = 0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (out_valid && out_idx == 20) begin
                found = 1;
                break;
            end
        end
        chk("reach_idx20", found, 1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_last", int'(out_last), 0);
        chk("mid_rst_idx", int'(out_idx), 0);
        chk("mid_rst_re", int'(tw_re), 0);
        chk("mid_rst_im", int'(tw_im), 0);
        sb.delete();
        tick();
        tick();
        rstn = 1'b1;
        found = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (done || out_valid || busy) found = 1;
        end
        chk("post_rst_idle", found, 0);
        do_start(1'b0);
        run_until_done(1'b0, 0, dcyc);
        chk("rst_first_lat", first_cyc - start_cyc, 2);
        chk("rst_re0", got_re[0], 128);
        chk("rst_im0", got_im[0], 0);
        chk("sb_empty_rst", sb.size(), 0);

        for (int t = 0; t < 2000 && n2 < N2; t++) tick();
        chk("wide_count", n2, N2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
